// File: rtl/fib_sequencer.sv
// fib_sequencer: control sequencer that walks the shared ALU/register-file
// datapath through a Fibonacci-style run of programmable length.
// Step 0 loads the seed into R1 (add-immediate). Each later step adds the
// two previously written registers into the next register. Destinations
// rotate through R1..R(NREGS-1), so runs may be longer than the register file.
// Optional feature: define FIB_SEQ_LOOP_EN to restart the captured run
// forever instead of returning to idle.
// REG_AW is intended to lie in 2..4.
module fib_sequencer #(
  parameter int         REG_AW  = 4,
  parameter int         DATA_W  = 16,
  parameter int         LEN_W   = 16,
  parameter logic [7:0] OP_ADD  = 8'h05,
  parameter logic [7:0] OP_ADDI = 8'h50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step_en,
  input  logic [LEN_W-1:0]       length,
  input  logic [DATA_W-1:0]      seed,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             alu_op,
  output logic [2*REG_AW-1:0]    muxes,
  output logic [(1<<REG_AW)-1:0] regs_en,
  output logic [DATA_W-1:0]      imm
);

  localparam int NREGS = 1 << REG_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_DONE} state_t;

  // Next destination register; R0 is skipped so it keeps reading as zero.
  function automatic logic [REG_AW-1:0] next_dest(input logic [REG_AW-1:0] d);
    if (d == REG_AW'(NREGS - 1)) return REG_AW'(1);
    return d + 1'b1;
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [REG_AW-1:0] d);
    return NREGS'(1) << d;
  endfunction

  state_t              state_q, state_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [LEN_W-1:0]    cnt_q, cnt_n;
  logic [LEN_W-1:0]    cnt_inc;
  logic                last_word;
  logic [REG_AW-1:0]   dest_q, dest_n;
  logic [REG_AW-1:0]   src_a_q, src_a_n;
  logic [REG_AW-1:0]   src_b_q, src_b_n;
  logic [7:0]          alu_op_q, alu_op_n;
  logic [DATA_W-1:0]   imm_q, imm_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
`ifdef FIB_SEQ_LOOP_EN
  logic [DATA_W-1:0]   seed_q, seed_n;
`endif

  // Counter never exceeds len_q, so the increment cannot overflow.
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (cnt_inc == len_q);

  assign busy    = busy_q;
  assign done    = done_q;
  assign alu_op  = alu_op_q;
  assign muxes   = {src_a_q, src_b_q};
  assign imm     = imm_q;

  // Write enable is the only combinational output: gated by step_en so a
  // stalled word never writes.
  assign regs_en = (((state_q == ST_INIT) || (state_q == ST_RUN)) && step_en)
                   ? onehot(dest_q) : '0;

  // State and registered-output update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      alu_op_q <= '0;
      imm_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIB_SEQ_LOOP_EN
      seed_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      dest_q   <= dest_n;
      src_a_q  <= src_a_n;
      src_b_q  <= src_b_n;
      alu_op_q <= alu_op_n;
      imm_q    <= imm_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
`ifdef FIB_SEQ_LOOP_EN
      seed_q   <= seed_n;
`endif
    end
  end

  // Next state and next control word; everything holds unless a word is
  // consumed or a run is started.
  always_comb begin
    state_n  = state_q;
    len_n    = len_q;
    cnt_n    = cnt_q;
    dest_n   = dest_q;
    src_a_n  = src_a_q;
    src_b_n  = src_b_q;
    alu_op_n = alu_op_q;
    imm_n    = imm_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
`ifdef FIB_SEQ_LOOP_EN
    seed_n   = seed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_n = length;
          cnt_n = '0;
`ifdef FIB_SEQ_LOOP_EN
          seed_n = seed;
`endif
          if (length == '0) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n  = ST_INIT;
            busy_n   = 1'b1;
            alu_op_n = OP_ADDI;
            src_a_n  = '0;
            src_b_n  = '0;
            dest_n   = REG_AW'(1);
            imm_n    = seed;
          end
        end
      end
      ST_INIT, ST_RUN: begin
        if (step_en) begin
          if (last_word) begin
            cnt_n  = '0;
            done_n = 1'b1;
`ifdef FIB_SEQ_LOOP_EN
            // Restart the captured run immediately with the INIT word.
            state_n  = ST_INIT;
            busy_n   = 1'b1;
            alu_op_n = OP_ADDI;
            src_a_n  = '0;
            src_b_n  = '0;
            dest_n   = REG_AW'(1);
            imm_n    = seed_q;
`else
            state_n  = ST_DONE;
            busy_n   = 1'b0;
            alu_op_n = '0;
            src_a_n  = '0;
            src_b_n  = '0;
            dest_n   = '0;
            imm_n    = '0;
`endif
          end else begin
            // Sources slide along the destination history: {d(k-1), d(k)}.
            state_n  = ST_RUN;
            cnt_n    = cnt_inc;
            alu_op_n = OP_ADD;
            src_a_n  = src_b_q;
            src_b_n  = dest_q;
            dest_n   = next_dest(dest_q);
            imm_n    = '0;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
